core_mem_arbiter: RTL and testbench

- Shares one single-ported memory bus between the instruction-fetch stage and the LSU.
- Round-robin arbitration; one transaction outstanding at a time.
- Registered request drive toward memory; each response is routed back to the requester that owns the transaction.
- Sits between if_stage/LSU and the external memory interface at the core boundary.

---
 rtl/core_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory bus between instruction fetch and the LSU.
// Optional response timeout: define CORE_MEM_ARB_TIMEOUT_EN (uses TIMEOUT_CYCLES).
module core_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              rsp_err_o,
    output logic              arb_busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              lsu_rvalid_q, lsu_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
    logic              sel_lsu;
    logic              rsp_fire;
    logic [DATA_W-1:0] rsp_data;

`ifdef CORE_MEM_ARB_TIMEOUT_EN
    localparam int                CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rvalid_d  = 1'b0;
        lsu_rvalid_d = 1'b0;
        if_rdata_d   = if_rdata_q;
        lsu_rdata_d  = lsu_rdata_q;
        sel_lsu      = 1'b0;
        rsp_fire     = 1'b0;
        rsp_data     = '0;
`ifdef CORE_MEM_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        rsp_err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (if_req_i || lsu_req_i) begin
                    // On a tie the requester that did not own the last transaction wins.
                    sel_lsu     = lsu_req_i && (!if_req_i || (last_owner_q == OWN_IF));
                    owner_d     = sel_lsu;
                    mem_req_d   = 1'b1;
                    mem_we_d    = sel_lsu && lsu_we_i;
                    mem_addr_d  = sel_lsu ? lsu_addr_i : if_addr_i;
                    mem_wdata_d = sel_lsu ? lsu_wdata_i : '0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    mem_req_d    = 1'b0;
                    last_owner_d = owner_q;
                    state_d      = ST_WAIT;
`ifdef CORE_MEM_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    rsp_fire = 1'b1;
                    rsp_data = mem_we_q ? '0 : mem_rdata_i;
                end
`ifdef CORE_MEM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_MAX) begin
                    rsp_fire  = 1'b1;
                    rsp_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
                if (rsp_fire) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rsp_fire) begin
            if (owner_q == OWN_LSU) begin
                lsu_rvalid_d = 1'b1;
                lsu_rdata_d  = rsp_data;
            end else begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = rsp_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_LSU;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rvalid_q  <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            if_rdata_q   <= '0;
            lsu_rdata_q  <= '0;
`ifdef CORE_MEM_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rvalid_q  <= if_rvalid_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            lsu_rdata_q  <= lsu_rdata_d;
`ifdef CORE_MEM_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    // Grants pass mem_gnt_i straight through to the current owner.
    assign if_gnt_o     = (state_q == ST_REQ) && (owner_q == OWN_IF) && mem_gnt_i;
    assign lsu_gnt_o    = (state_q == ST_REQ) && (owner_q == OWN_LSU) && mem_gnt_i;
    assign if_rvalid_o  = if_rvalid_q;
    assign if_rdata_o   = if_rdata_q;
    assign lsu_rvalid_o = lsu_rvalid_q;
    assign lsu_rdata_o  = lsu_rdata_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign arb_busy_o   = (state_q != ST_IDLE);
`ifdef CORE_MEM_ARB_TIMEOUT_EN
    assign rsp_err_o    = rsp_err_q;
`else
    assign rsp_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed self-checking bench for core_mem_arbiter; timeout scenario follows CORE_MEM_ARB_TIMEOUT_EN.
module tb_core_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        lsu_req_i = 1'b0, lsu_we_i = 1'b0;
    logic [31:0] lsu_addr_i = '0, lsu_wdata_i = '0;
    logic        lsu_gnt_o, lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        rsp_err_o, arb_busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        if_gnt;
        logic        lsu_gnt;
        logic        if_rv;
        logic        lsu_rv;
        logic [31:0] if_rd;
        logic [31:0] lsu_rd;
        logic        err;
    } txn_t;

    core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .rsp_err_o(rsp_err_o), .arb_busy_o(arb_busy_o)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Sample point is 2 time units after each rising edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Entered at the sample point of the first REQ cycle: grant at once, respond in the first WAIT cycle.
    task automatic serve(input logic [31:0] rd, output txn_t t);
        t.addr  = mem_addr_o;
        t.we    = mem_we_o;
        t.wdata = mem_wdata_o;
        mem_gnt_i = 1'b1;
        #1;
        t.if_gnt  = if_gnt_o;
        t.lsu_gnt = lsu_gnt_o;
        tick();
        mem_gnt_i = 1'b0;
        if (t.if_gnt)  if_req_i  = 1'b0;
        if (t.lsu_gnt) lsu_req_i = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rd;
        tick();
        mem_rvalid_i = 1'b0;
        t.if_rv  = if_rvalid_o;
        t.lsu_rv = lsu_rvalid_o;
        t.if_rd  = if_rdata_o;
        t.lsu_rd = lsu_rdata_o;
        t.err    = rsp_err_o;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_gnt_o, lsu_gnt_o, if_rvalid_o,
             lsu_rvalid_o, if_rdata_o, lsu_rdata_o, rsp_err_o, arb_busy_o} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: some output nonzero, addr=%h busy=%b", mem_addr_o, arb_busy_o);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (arb_busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b req=%b want 0 0", arb_busy_o, mem_req_o);
        end
    endtask

    task automatic test_fetch_only();
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0100;
        tick();
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 32'h100}) begin
            n_fail++; $display("FAIL fetch_mem_drive: req=%b we=%b addr=%h want 1 0 00000100", mem_req_o, mem_we_o, mem_addr_o);
        end
        n_checks++;
        if (if_gnt_o !== 1'b0 || arb_busy_o !== 1'b1) begin
            n_fail++; $display("FAIL fetch_pre_gnt: gnt=%b busy=%b want 0 1", if_gnt_o, arb_busy_o);
        end
        mem_gnt_i = 1'b1;
        #1;
        n_checks++;
        if ({if_gnt_o, lsu_gnt_o} !== 2'b10) begin
            n_fail++; $display("FAIL fetch_gnt: if_gnt=%b lsu_gnt=%b want 1 0", if_gnt_o, lsu_gnt_o);
        end
        tick();
        mem_gnt_i = 1'b0;
        if_req_i  = 1'b0;
        n_checks++;
        if (mem_req_o !== 1'b0 || if_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL fetch_wait: mem_req=%b if_gnt=%b want 0 0", mem_req_o, if_gnt_o);
        end
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid_i = 1'b0;
        n_checks++;
        if ({if_rvalid_o, if_rdata_o, rsp_err_o, arb_busy_o} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL fetch_rsp: rvalid=%b rdata=%h err=%b busy=%b want 1 deadbeef 0 0",
                               if_rvalid_o, if_rdata_o, rsp_err_o, arb_busy_o);
        end
        n_checks++;
        if ({lsu_rvalid_o, lsu_rdata_o, lsu_gnt_o} !== '0) begin
            n_fail++; $display("FAIL fetch_lsu_quiet: lsu_rvalid=%b lsu_rdata=%h want 0 0", lsu_rvalid_o, lsu_rdata_o);
        end
        tick();
        n_checks++;
        if (if_rvalid_o !== 1'b0 || if_rdata_o !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL fetch_pulse_end: rvalid=%b rdata=%h want 0 deadbeef", if_rvalid_o, if_rdata_o);
        end
    endtask

    task automatic test_tie_round_robin();
        txn_t t;
        pulse_reset();
        if_addr_i   = 32'h0000_0100;
        lsu_we_i    = 1'b1;
        lsu_addr_i  = 32'h0000_2000;
        lsu_wdata_i = 32'h0000_1234;
        for (int round = 0; round < 2; round++) begin
            if_req_i  = 1'b1;
            lsu_req_i = 1'b1;
            tick();
            serve(32'hA000_0000 + 32'(round), t);
            n_checks++;
            if ({t.if_gnt, t.lsu_gnt, t.addr, t.we, t.wdata} !== {2'b10, 32'h100, 1'b0, 32'h0}) begin
                n_fail++; $display("FAIL tie_if_first[%0d]: gnt if/lsu=%b%b addr=%h we=%b wdata=%h want 10 00000100 0 0",
                                   round, t.if_gnt, t.lsu_gnt, t.addr, t.we, t.wdata);
            end
            n_checks++;
            if ({t.if_rv, t.lsu_rv, t.if_rd} !== {2'b10, 32'hA000_0000 + 32'(round)}) begin
                n_fail++; $display("FAIL tie_if_rsp[%0d]: rv if/lsu=%b%b rdata=%h want 10 %h",
                                   round, t.if_rv, t.lsu_rv, t.if_rd, 32'hA000_0000 + 32'(round));
            end
            tick();
            serve(32'h5555_5555, t);
            n_checks++;
            if ({t.if_gnt, t.lsu_gnt, t.addr, t.we, t.wdata} !== {2'b01, 32'h2000, 1'b1, 32'h1234}) begin
                n_fail++; $display("FAIL tie_lsu_second[%0d]: gnt if/lsu=%b%b addr=%h we=%b wdata=%h want 01 00002000 1 00001234",
                                   round, t.if_gnt, t.lsu_gnt, t.addr, t.we, t.wdata);
            end
            n_checks++;
            if ({t.if_rv, t.lsu_rv, t.lsu_rd, t.err} !== {2'b01, 32'h0, 1'b0}) begin
                n_fail++; $display("FAIL tie_lsu_rsp[%0d]: rv if/lsu=%b%b rdata=%h err=%b want 01 0 0",
                                   round, t.if_rv, t.lsu_rv, t.lsu_rd, t.err);
            end
        end
    endtask

    task automatic test_grant_stall();
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_addr_i = 32'h0000_3000;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({mem_req_o, mem_addr_o, lsu_gnt_o, if_gnt_o} !== {1'b1, 32'h3000, 2'b00}) begin
                n_fail++; $display("FAIL stall_hold[%0d]: req=%b addr=%h gnt lsu/if=%b%b want 1 00003000 00",
                                   i, mem_req_o, mem_addr_o, lsu_gnt_o, if_gnt_o);
            end
            tick();
        end
        mem_gnt_i = 1'b1;
        #1;
        n_checks++;
        if ({mem_req_o, mem_addr_o, lsu_gnt_o} !== {1'b1, 32'h3000, 1'b1}) begin
            n_fail++; $display("FAIL stall_gnt: req=%b addr=%h lsu_gnt=%b want 1 00003000 1", mem_req_o, mem_addr_o, lsu_gnt_o);
        end
        tick();
        mem_gnt_i    = 1'b0;
        lsu_req_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0BAD_F00D;
        tick();
        mem_rvalid_i = 1'b0;
        n_checks++;
        if ({lsu_rvalid_o, lsu_rdata_o} !== {1'b1, 32'h0BAD_F00D}) begin
            n_fail++; $display("FAIL stall_rsp: rvalid=%b rdata=%h want 1 0badf00d", lsu_rvalid_o, lsu_rdata_o);
        end
    endtask

    task automatic test_back_to_back();
        int rises = 0, last_rise = 0, rv_count = 0;
        logic prev_req = 1'b0, prev_gnt = 1'b0;
        if_addr_i   = 32'h0000_0800;
        if_req_i    = 1'b1;
        mem_rdata_i = 32'h1111_0000;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (if_rvalid_o) rv_count++;
            if (mem_req_o && !prev_req) begin
                if (rises > 0) begin
                    n_checks++;
                    if (i - last_rise !== 3) begin
                        n_fail++; $display("FAIL b2b_spacing: got %0d cycles want 3", i - last_rise);
                    end
                end
                rises++;
                last_rise = i;
            end
            prev_req     = mem_req_o;
            mem_rvalid_i = prev_gnt;
            mem_gnt_i    = mem_req_o;
            prev_gnt     = mem_gnt_i;
            if (i == 12) if_req_i = 1'b0;
        end
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        n_checks++;
        if (rises !== 4 || rv_count !== 4 || arb_busy_o !== 1'b0) begin
            n_fail++; $display("FAIL b2b_count: reqs=%0d rvalids=%0d busy=%b want 4 4 0", rises, rv_count, arb_busy_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0400;
        tick();
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        if_req_i  = 1'b0;
        n_checks++;
        if (arb_busy_o !== 1'b1 || mem_addr_o !== 32'h400) begin
            n_fail++; $display("FAIL midwait_setup: busy=%b addr=%h want 1 00000400", arb_busy_o, mem_addr_o);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_req_o, mem_addr_o, if_rdata_o, arb_busy_o, if_rvalid_o} !== '0) begin
            n_fail++; $display("FAIL midwait_async_reset: req=%b addr=%h rdata=%h busy=%b want all 0",
                               mem_req_o, mem_addr_o, if_rdata_o, arb_busy_o);
        end
        tick();
        reset        = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_CAFE;
        tick();
        mem_rvalid_i = 1'b0;
        n_checks++;
        if ({if_rvalid_o, lsu_rvalid_o, if_rdata_o, arb_busy_o} !== '0) begin
            n_fail++; $display("FAIL midwait_late_rsp: rv if/lsu=%b%b rdata=%h busy=%b want 0 0 0 0",
                               if_rvalid_o, lsu_rvalid_o, if_rdata_o, arb_busy_o);
        end
    endtask

    task automatic test_spurious_rvalid();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_0077;
        tick();
        tick();
        mem_rvalid_i = 1'b0;
        n_checks++;
        if ({if_rvalid_o, lsu_rvalid_o, arb_busy_o, mem_req_o, if_rdata_o, lsu_rdata_o} !== '0) begin
            n_fail++; $display("FAIL spurious_rvalid: rv if/lsu=%b%b busy=%b req=%b rdata if/lsu=%h/%h want all 0",
                               if_rvalid_o, lsu_rvalid_o, arb_busy_o, mem_req_o, if_rdata_o, lsu_rdata_o);
        end
    endtask

    task automatic test_timeout();
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_addr_i = 32'h0000_0500;
        tick();
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        lsu_req_i = 1'b0;
`ifdef CORE_MEM_ARB_TIMEOUT_EN
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (lsu_rvalid_o !== 1'b0 || arb_busy_o !== 1'b1) begin
                n_fail++; $display("FAIL timeout_wait[%0d]: rvalid=%b busy=%b want 0 1", i, lsu_rvalid_o, arb_busy_o);
            end
            if (i < 4) tick();
        end
        tick();
        n_checks++;
        if ({lsu_rvalid_o, rsp_err_o, lsu_rdata_o, arb_busy_o} !== {2'b11, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL timeout_rsp: rvalid=%b err=%b rdata=%h busy=%b want 1 1 0 0",
                               lsu_rvalid_o, rsp_err_o, lsu_rdata_o, arb_busy_o);
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_0099;
        tick();
        mem_rvalid_i = 1'b0;
        n_checks++;
        if ({lsu_rvalid_o, rsp_err_o, lsu_rdata_o} !== '0) begin
            n_fail++; $display("FAIL timeout_late_rsp: rvalid=%b err=%b rdata=%h want 0 0 0",
                               lsu_rvalid_o, rsp_err_o, lsu_rdata_o);
        end
`else
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({lsu_rvalid_o, rsp_err_o, arb_busy_o} !== 3'b001) begin
                n_fail++; $display("FAIL nowait_limit[%0d]: rvalid=%b err=%b busy=%b want 0 0 1",
                                   i, lsu_rvalid_o, rsp_err_o, arb_busy_o);
            end
            tick();
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_ABCD;
        tick();
        mem_rvalid_i = 1'b0;
        n_checks++;
        if ({lsu_rvalid_o, rsp_err_o, lsu_rdata_o, arb_busy_o} !== {2'b10, 32'h0000_ABCD, 1'b0}) begin
            n_fail++; $display("FAIL nowait_rsp: rvalid=%b err=%b rdata=%h busy=%b want 1 0 0000abcd 0",
                               lsu_rvalid_o, rsp_err_o, lsu_rdata_o, arb_busy_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_tie_round_robin();
        test_grant_stall();
        test_back_to_back();
        test_reset_mid_wait();
        test_spurious_rvalid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
